// File: rtl/split_n_sync_if.sv
// rtl/split_n_sync_if.sv - upstream/downstream handshake bundle for split_n_sync
interface split_n_sync_if #(
  parameter int N_CH   = 3,
  parameter int DATA_W = 32
);
  logic              req_in;
  logic [6:0]        opcode;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic [N_CH-1:0]   req_out;
  logic [DATA_W-1:0] data_out;
  logic [N_CH-1:0]   ack_in;
  logic [N_CH-1:0]   ch_sel;
  logic              busy;
  logic              err_illegal;
  logic              timeout_err;
  logic              err_clr;

  modport slave (
    input  req_in, opcode, data_in, ack_in, err_clr,
    output ack_out, req_out, data_out, ch_sel, busy, err_illegal, timeout_err
  );

  modport master (
    output req_in, opcode, data_in, ack_in, err_clr,
    input  ack_out, req_out, data_out, ch_sel, busy, err_illegal, timeout_err
  );
endinterface

// File: rtl/split_n_sync.sv
// rtl/split_n_sync.sv - four-phase request splitter routing by RV32 opcode
module split_n_sync #(
  parameter int N_CH    = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  split_n_sync_if.slave  bus
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (N_CH != 3 && N_CH != 4) begin : g_bad_n_ch
      $error("split_n_sync: N_CH must be 3 or 4");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_REL, S_DROP} state_t;

  // U-type lands on the last channel: ch3 with four channels, ch2 with three.
  function automatic logic [N_CH-1:0] decode(input logic [6:0] op);
    logic [N_CH-1:0] oh;
    oh = '0;
    case (op)
      7'b1100011, 7'b1101111:             oh[0] = 1'b1;
      7'b0000011, 7'b0100011:             oh[1] = 1'b1;
      7'b0110011, 7'b0010011, 7'b0000000: oh[2] = 1'b1;
      7'b0110111:                         oh[N_CH-1] = 1'b1;
      default:                            oh = '0;
    endcase
    return oh;
  endfunction

  state_t            state_q, state_d;
  logic              req_s_q, req_s_d;
  logic [6:0]        op_s_q, op_s_d;
  logic [DATA_W-1:0] data_s_q, data_s_d;
  logic [N_CH-1:0]   ack_s_q, ack_s_d;
  logic [N_CH-1:0]   req_out_q, req_out_d;
  logic [N_CH-1:0]   ch_sel_q, ch_sel_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ack_out_q, ack_out_d;
  logic              busy_q, busy_d;
  logic              err_illegal_q, err_illegal_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   dec;
  logic              ack_sel;
  logic              wait_tick;

  always_comb begin
    req_s_d       = bus.req_in;
    op_s_d        = bus.opcode;
    data_s_d      = bus.data_in;
    ack_s_d       = bus.ack_in;
    state_d       = state_q;
    req_out_d     = req_out_q;
    ch_sel_d      = ch_sel_q;
    data_out_d    = data_out_q;
    ack_out_d     = ack_out_q;
    err_illegal_d = 1'b0;
    cnt_d         = cnt_q;
    wait_tick     = 1'b0;
    dec           = decode(op_s_q);
    ack_sel       = |(ack_s_q & ch_sel_q);

    case (state_q)
      S_IDLE: begin
        if (req_s_q) begin
          data_out_d = data_s_q;
          ch_sel_d   = dec;
          cnt_d      = '0;
          if (|dec) begin
            req_out_d = dec;
            state_d   = S_REQ;
          end else begin
            err_illegal_d = 1'b1;
            state_d       = S_DROP;
          end
        end
      end
      S_REQ: begin
        if (ack_sel) begin
          ack_out_d = 1'b1;
          state_d   = S_ACK;
        end else begin
          wait_tick = 1'b1;
        end
      end
      S_ACK: begin
        if (!req_s_q) begin
          req_out_d = '0;
          cnt_d     = '0;
          state_d   = S_REL;
        end
      end
      S_REL: begin
        if (!ack_sel) begin
          ack_out_d = 1'b0;
          ch_sel_d  = '0;
          state_d   = S_IDLE;
        end else begin
          wait_tick = 1'b1;
        end
      end
      S_DROP: begin
        ack_out_d = req_s_q;
        if (!req_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wait_tick && cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + CNT_W'(1);

    // A timeout raised in the same cycle as err_clr must not be lost.
    timeout_err_d = timeout_err_q;
    if (bus.err_clr) timeout_err_d = 1'b0;
    if (wait_tick && TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) timeout_err_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_s_q       <= 1'b0;
      op_s_q        <= '0;
      data_s_q      <= '0;
      ack_s_q       <= '0;
      req_out_q     <= '0;
      ch_sel_q      <= '0;
      data_out_q    <= '0;
      ack_out_q     <= 1'b0;
      busy_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_s_q       <= req_s_d;
      op_s_q        <= op_s_d;
      data_s_q      <= data_s_d;
      ack_s_q       <= ack_s_d;
      req_out_q     <= req_out_d;
      ch_sel_q      <= ch_sel_d;
      data_out_q    <= data_out_d;
      ack_out_q     <= ack_out_d;
      busy_q        <= busy_d;
      err_illegal_q <= err_illegal_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.req_out     = req_out_q;
  assign bus.ch_sel      = ch_sel_q;
  assign bus.data_out    = data_out_q;
  assign bus.ack_out     = ack_out_q;
  assign bus.busy        = busy_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_split_n_sync.sv
// tb/tb_split_n_sync.sv - scoreboard bench running 3- and 4-channel splitters in lockstep
module tb_split_n_sync;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    bit              legal;
    int              ch3;
    int              ch4;
    logic [DW-1:0]   data;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   exp_to = 1'b0;
  logic [2:0] cur_oh3 = '0;
  logic [3:0] cur_oh4 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  split_n_sync_if #(.N_CH(3), .DATA_W(DW)) if3 ();
  split_n_sync_if #(.N_CH(4), .DATA_W(DW)) if4 ();

  split_n_sync #(.N_CH(3), .DATA_W(DW), .TIMEOUT(TO)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  split_n_sync #(.N_CH(4), .DATA_W(DW), .TIMEOUT(TO)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference routing table: channel index, or -1 for an illegal opcode.
  function automatic int ref_ch(input logic [6:0] op, input int n_ch);
    case (op)
      7'b1100011, 7'b1101111:             return 0;
      7'b0000011, 7'b0100011:             return 1;
      7'b0110011, 7'b0010011, 7'b0000000: return 2;
      7'b0110111:                         return (n_ch == 4) ? 3 : 2;
      default:                            return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_up(input logic r, input logic [6:0] op, input logic [DW-1:0] d);
    if3.req_in = r;  if4.req_in = r;
    if3.opcode = op; if4.opcode = op;
    if3.data_in = d; if4.data_in = d;
  endtask

  task automatic drive_ack(input bit hit, input bit noise);
    logic [3:0] rnd;
    rnd = 4'($urandom);
    if3.ack_in = (hit ? cur_oh3 : 3'b000) | (noise ? (rnd[2:0] & ~cur_oh3) : 3'b000);
    if4.ack_in = (hit ? cur_oh4 : 4'b0000) | (noise ? (rnd & ~cur_oh4) : 4'b0000);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_out3"},  64'(if3.req_out), 0);
    chk({tag, "_req_out4"},  64'(if4.req_out), 0);
    chk({tag, "_ack_out3"},  64'(if3.ack_out), 0);
    chk({tag, "_ack_out4"},  64'(if4.ack_out), 0);
    chk({tag, "_ch_sel3"},   64'(if3.ch_sel), 0);
    chk({tag, "_ch_sel4"},   64'(if4.ch_sel), 0);
    chk({tag, "_busy3"},     64'(if3.busy), 0);
    chk({tag, "_busy4"},     64'(if4.busy), 0);
    chk({tag, "_illegal3"},  64'(if3.err_illegal), 0);
    chk({tag, "_timeout3"},  64'(if3.timeout_err), 0);
    chk({tag, "_data_out3"}, 64'(if3.data_out), 0);
    chk({tag, "_data_out4"}, 64'(if4.data_out), 0);
  endtask

  task automatic txn(input logic [6:0] op, input logic [DW-1:0] data, input int ack_dly,
                     input int rel_dly, input int up_dly, input bit noise, input bit abort);
    exp_t e;
    int   n;
    e.ch3   = ref_ch(op, 3);
    e.ch4   = ref_ch(op, 4);
    e.legal = (e.ch3 >= 0);
    e.data  = data;
    cur_oh3 = e.legal ? 3'(1 << e.ch3) : 3'b000;
    cur_oh4 = e.legal ? 4'(1 << e.ch4) : 4'b0000;
    tick();
    e.cyc = cyc + 2;
    sb.push_back(e);
    drive_up(1'b1, op, data);
    tick();
    drive_up(1'b1, 7'($urandom), DW'($urandom));
    if (e.legal) begin
      n = 0;
      do begin tick(); n++; end while (!(|if3.req_out) && n < 20);
      chk("req_out_seen", 64'(|if3.req_out), 1);
      for (int i = 0; i < ack_dly; i++) begin
        drive_ack(1'b0, noise);
        chk("ack_out_while_waiting", 64'(if3.ack_out | if4.ack_out), 0);
        chk("timeout_timing", 64'(if3.timeout_err), 64'(i >= TO));
        tick();
      end
      drive_ack(1'b1, noise);
      tick();
      chk("ack_out_latency_lo", 64'(if3.ack_out | if4.ack_out), 0);
      drive_ack(1'b1, noise);
      tick();
      chk("ack_out_latency_hi3", 64'(if3.ack_out), 1);
      chk("ack_out_latency_hi4", 64'(if4.ack_out), 1);
      if (abort) begin
        rst = 1'b1;
        tick();
        chk_quiet("abort");
        rst = 1'b0;
        drive_up(1'b0, 7'd0, '0);
        if3.ack_in = '0;
        if4.ack_in = '0;
        exp_to = 1'b0;
        return;
      end
      if (ack_dly + 1 >= TO) exp_to = 1'b1;
      for (int i = 0; i < up_dly; i++) begin drive_ack(1'b1, noise); tick(); end
      drive_up(1'b0, 7'($urandom), DW'($urandom));
      n = 0;
      do begin drive_ack(1'b1, noise); tick(); n++; end while ((|if3.req_out) && n < 20);
      chk("req_out_released", 64'((|if3.req_out) | (|if4.req_out)), 0);
      chk("ack_out_held_in_release", 64'(if3.ack_out & if4.ack_out), 1);
      for (int i = 0; i < rel_dly; i++) begin drive_ack(1'b1, noise); tick(); end
      drive_ack(1'b0, noise);
      if (rel_dly + 1 >= TO) exp_to = 1'b1;
    end else begin
      tick();
      chk("drop_ack_out_lo", 64'(if3.ack_out | if4.ack_out), 0);
      tick();
      chk("drop_ack_out_hi3", 64'(if3.ack_out), 1);
      chk("drop_ack_out_hi4", 64'(if4.ack_out), 1);
      chk("drop_req_out", 64'((|if3.req_out) | (|if4.req_out)), 0);
      for (int i = 0; i < up_dly; i++) tick();
      drive_up(1'b0, 7'($urandom), DW'($urandom));
    end
    n = 0;
    do begin tick(); n++; end while ((if3.ack_out || if4.ack_out) && n < 20);
    if3.ack_in = '0;
    if4.ack_in = '0;
    chk("idle_ack_out", 64'(if3.ack_out | if4.ack_out), 0);
    chk("idle_busy", 64'(if3.busy | if4.busy), 0);
    chk("idle_ch_sel", 64'((|if3.ch_sel) | (|if4.ch_sel)), 0);
    chk("idle_req_out", 64'((|if3.req_out) | (|if4.req_out)), 0);
    chk("timeout_err3", 64'(if3.timeout_err), 64'(exp_to));
    chk("timeout_err4", 64'(if4.timeout_err), 64'(exp_to));
    if (exp_to) begin
      if3.err_clr = 1'b1; if4.err_clr = 1'b1;
      tick();
      if3.err_clr = 1'b0; if4.err_clr = 1'b0;
      chk("timeout_cleared", 64'(if3.timeout_err | if4.timeout_err), 0);
      exp_to = 1'b0;
    end
  endtask

  logic          prev3 = 1'b0;
  logic          prev4 = 1'b0;
  logic [DW-1:0] hold_data = '0;
  bit            ev3, ev4;
  exp_t          me;

  always @(negedge clk) begin
    if (!rst) begin
      ev3 = ((|if3.req_out) && !prev3) || if3.err_illegal;
      ev4 = ((|if4.req_out) && !prev4) || if4.err_illegal;
      if (ev3 || ev4) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: actual=dut event expected=none (cycle %0d)", cyc);
        end else begin
          me = sb.pop_front();
          hold_data = me.data;
          chk("event_cycle", 64'(cyc), 64'(me.cyc));
          chk("event_dut3", 64'(ev3), 1);
          chk("event_dut4", 64'(ev4), 1);
          chk("req_out3", 64'(if3.req_out), me.legal ? (64'(1) << me.ch3) : 64'(0));
          chk("req_out4", 64'(if4.req_out), me.legal ? (64'(1) << me.ch4) : 64'(0));
          chk("ch_sel3", 64'(if3.ch_sel), me.legal ? (64'(1) << me.ch3) : 64'(0));
          chk("ch_sel4", 64'(if4.ch_sel), me.legal ? (64'(1) << me.ch4) : 64'(0));
          chk("err_illegal3", 64'(if3.err_illegal), 64'(!me.legal));
          chk("err_illegal4", 64'(if4.err_illegal), 64'(!me.legal));
          chk("data_out3", 64'(if3.data_out), 64'(me.data));
          chk("data_out4", 64'(if4.data_out), 64'(me.data));
        end
      end else if (|if3.req_out) begin
        chk("data_hold3", 64'(if3.data_out), 64'(hold_data));
        chk("data_hold4", 64'(if4.data_out), 64'(hold_data));
        chk("req_out_in_ch_sel3", 64'(if3.req_out & ~if3.ch_sel), 0);
        chk("illegal_pulse_width", 64'(if3.err_illegal | if4.err_illegal), 0);
      end
    end
    prev3 = |if3.req_out;
    prev4 = |if4.req_out;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=still running expected=finished (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [6:0] legal_ops [9];
    logic [6:0] op;
    legal_ops = '{7'b1100011, 7'b1101111, 7'b0000011, 7'b0100011, 7'b0110011,
                  7'b0010011, 7'b0000000, 7'b0110111, 7'b0110011};
    drive_up(1'b0, 7'd0, '0);
    if3.ack_in = '0;    if4.ack_in = '0;
    if3.err_clr = 1'b0; if4.err_clr = 1'b0;
    repeat (3) tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();

    txn(7'b0110011, 32'hDEADBEEF, 0, 0, 0, 1'b0, 1'b0);
    txn(7'b0110111, 32'h00001234, 1, 1, 1, 1'b0, 1'b0);
    txn(7'b1111111, 32'hBAD00000, 0, 0, 2, 1'b0, 1'b0);
    txn(7'b0000011, 32'h00000011, 10, 0, 0, 1'b0, 1'b0);
    txn(7'b0100011, 32'h00000022, 2, 2, 0, 1'b0, 1'b0);
    txn(7'b1100011, 32'h00000033, 3, 0, 0, 1'b0, 1'b0);
    txn(7'b0000011, 32'h00000044, 0, 3, 0, 1'b0, 1'b0);
    txn(7'b0000011, 32'h00000055, 3, 1, 1, 1'b1, 1'b0);
    txn(7'b0010011, 32'h00000066, 1, 0, 3, 1'b0, 1'b1);
    txn(7'b1101111, 32'h00000077, 0, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) op = legal_ops[$urandom_range(0, 8)];
      else op = 7'($urandom);
      txn(op, DW'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    tick();
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
